// File: rtl/pc_fetch_gen_pkg.sv
// Shared definitions for the fetch PC generator: reset vector, PC step and FSM encoding.
// Optional feature macro used by this slice: PC_ALIGN_CHECK_EN.
package pc_fetch_gen_pkg;

   localparam int unsigned PC_AW = 32;

   localparam logic [PC_AW-1:0] PC_RESET_VEC = 32'hBFC0_0000;
   localparam logic [PC_AW-1:0] PC_STEP      = 32'd4;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_gen_redirect_buf.sv
// Redirect buffer: holds pending branch/exception redirects and resolves next_pc priority.
module pc_redirect_buf
   import pc_fetch_gen_pkg::*;
#(
   parameter int unsigned AW = PC_AW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          take,
   input  logic          flush_exc,
   input  logic [AW-1:0] exc_pc,
   input  logic          pcsrcD,
   input  logic [AW-1:0] branch_targetD,
   input  logic          jumpD,
   input  logic [AW-1:0] jump_targetD,
   input  logic [AW-1:0] pc_plus4,
   output logic [AW-1:0] next_pc_c,
   output logic          exc_sel_c
);

   logic          pend_br_v_q, pend_br_v_d;
   logic [AW-1:0] pend_br_pc_q, pend_br_pc_d;
   logic          pend_exc_v_q, pend_exc_v_d;
   logic [AW-1:0] pend_exc_pc_q, pend_exc_pc_d;
   logic          d_redir;
   logic [AW-1:0] d_target;

   always_comb begin
      d_redir  = pcsrcD | jumpD;
      d_target = pcsrcD ? branch_targetD : jump_targetD;
   end

   // Exception sources always win; a live D redirect beats a buffered one.
   always_comb begin
      next_pc_c = pc_plus4;
      exc_sel_c = 1'b0;
      if (flush_exc) begin
         next_pc_c = exc_pc;
         exc_sel_c = 1'b1;
      end else if (pend_exc_v_q) begin
         next_pc_c = pend_exc_pc_q;
         exc_sel_c = 1'b1;
      end else if (d_redir) begin
         next_pc_c = d_target;
      end else if (pend_br_v_q) begin
         next_pc_c = pend_br_pc_q;
      end
   end

   always_comb begin
      pend_br_v_d   = pend_br_v_q;
      pend_br_pc_d  = pend_br_pc_q;
      pend_exc_v_d  = pend_exc_v_q;
      pend_exc_pc_d = pend_exc_pc_q;

      if (flush_exc || take) begin
         pend_br_v_d = 1'b0;
      end else if (d_redir && !pend_exc_v_q) begin
         pend_br_v_d  = 1'b1;
         pend_br_pc_d = d_target;
      end

      if (take) begin
         pend_exc_v_d = 1'b0;
      end else if (flush_exc) begin
         pend_exc_v_d  = 1'b1;
         pend_exc_pc_d = exc_pc;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_br_v_q   <= 1'b0;
         pend_br_pc_q  <= '0;
         pend_exc_v_q  <= 1'b0;
         pend_exc_pc_q <= '0;
      end else begin
         pend_br_v_q   <= pend_br_v_d;
         pend_br_pc_q  <= pend_br_pc_d;
         pend_exc_v_q  <= pend_exc_v_d;
         pend_exc_pc_q <= pend_exc_pc_d;
      end
   end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC register and addr_ok-handshaked instruction request with delay-slot redirects.
// Define PC_ALIGN_CHECK_EN to add the adelF misaligned-fetch output.
module pc_fetch_gen
   import pc_fetch_gen_pkg::*;
#(
   parameter int unsigned   AW       = PC_AW,
   parameter logic [AW-1:0] RESET_PC = AW'(PC_RESET_VEC)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          stallF,
   input  logic          pcsrcD,
   input  logic [AW-1:0] branch_targetD,
   input  logic          jumpD,
   input  logic [AW-1:0] jump_targetD,
   input  logic          flush_exc,
   input  logic [AW-1:0] exc_pc,
   output logic          inst_req,
   output logic [AW-1:0] inst_addr,
   input  logic          inst_addr_ok,
   output logic [AW-1:0] pcF,
   output logic [AW-1:0] pc_plus4F,
`ifdef PC_ALIGN_CHECK_EN
   output logic          adelF,
`endif
   output logic          killF
);

   fetch_state_e  state_q, state_d;
   logic          req_en_q, req_en_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] pc_plus4;
   logic [AW-1:0] next_pc;
   logic          exc_sel;
   logic          accept;
   logic          take;
   logic          adel;

   always_comb begin
      pc_plus4  = pc_q + AW'(PC_STEP);
      inst_addr = pc_q;
      pcF       = pc_q;
      pc_plus4F = pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
      adel      = |pc_q[1:0];
      adelF     = adel;
`else
      adel      = 1'b0;
`endif
   end

   // State register; req_en_q keeps the request low until the first edge after reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_RUN;
         req_en_q <= 1'b0;
         pc_q     <= RESET_PC;
      end else begin
         state_q  <= state_d;
         req_en_q <= req_en_d;
         pc_q     <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (inst_req && !inst_addr_ok) state_d = ST_WAIT;
         ST_WAIT: if (inst_addr_ok)              state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Once issued, a request stays up until accepted regardless of stallF.
   always_comb begin
      inst_req = 1'b0;
      if (req_en_q && !adel) begin
         case (state_q)
            ST_RUN:  inst_req = ~stallF;
            ST_WAIT: inst_req = 1'b1;
            default: inst_req = 1'b0;
         endcase
      end
   end

   always_comb begin
      req_en_d = 1'b1;
      accept   = inst_req & inst_addr_ok;
      take     = accept | (adel & flush_exc);
      pc_d     = take ? next_pc : pc_q;
      killF    = accept & exc_sel;
   end

   pc_redirect_buf #(
      .AW (AW)
   ) u_redirect_buf (
      .clk            (clk),
      .resetn         (resetn),
      .take           (take),
      .flush_exc      (flush_exc),
      .exc_pc         (exc_pc),
      .pcsrcD         (pcsrcD),
      .branch_targetD (branch_targetD),
      .jumpD          (jumpD),
      .jump_targetD   (jump_targetD),
      .pc_plus4       (pc_plus4),
      .next_pc_c      (next_pc),
      .exc_sel_c      (exc_sel)
   );

endmodule
